// File: rtl/clk_div_gen_if.sv
// Divisor reload channel for clk_div_gen.
// Master offers div_in/div_valid; slave answers with div_ready.
interface clk_div_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;

    modport master (
        output div_in,
        output div_valid,
        input  div_ready
    );

    modport slave (
        input  div_in,
        input  div_valid,
        output div_ready
    );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable fabric-clock divider with glitch-free start/stop,
// a clk-domain tick per rising edge of o, and handshaked divisor reload.
module clk_div_gen #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    clk_div_gen_if.slave s_div,
    (* CLOCK *)
    output logic        o,
    output logic        tick,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_n;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_div_clamp;
    logic             r_pend_full;
    logic             r_o;
    logic             r_tick;
    logic             r_busy;
    logic             w_o_n;
    logic             w_tick_n;
    logic             w_wrap;
    logic             w_accept;

    assign w_half      = r_div >> 1;
    assign w_cnt_inc   = (r_cnt == r_div - WIDTH'(1)) ? '0 : r_cnt + WIDTH'(1);
    assign w_wrap      = (w_cnt_inc == '0) && (r_state != IDLE);
    assign w_accept    = s_div.div_valid && !r_pend_full;
    assign w_div_clamp = (s_div.div_in < WIDTH'(2)) ? WIDTH'(2) : s_div.div_in;

    assign s_div.div_ready = !r_pend_full;
    assign o    = r_o;
    assign tick = r_tick;
    assign busy = r_busy;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_o_n     = 1'b0;
        w_tick_n  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_n = RUN;
                    w_cnt_n   = '0;
                    w_o_n     = 1'b1;
                    w_tick_n  = 1'b1;
                end
            end
            RUN: begin
                w_cnt_n  = w_cnt_inc;
                w_o_n    = (w_cnt_inc < w_half);
                w_tick_n = w_wrap;
                if (!en) w_state_n = STOP;
            end
            STOP: begin
                // Leave only on a period boundary so o never gets a runt pulse
                if (!en && w_wrap) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n  = w_cnt_inc;
                    w_o_n    = (w_cnt_inc < w_half);
                    w_tick_n = w_wrap;
                    if (en) w_state_n = RUN;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_o         <= 1'b0;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_div       <= WIDTH'(RESET_DIV);
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_o     <= w_o_n;
            r_tick  <= w_tick_n;
            r_busy  <= (w_state_n != IDLE);
            // accept implies pending empty, so it never races the wrap update
            if (w_accept && r_state == IDLE) begin
                r_div <= w_div_clamp;
            end else if (w_accept) begin
                r_pend      <= w_div_clamp;
                r_pend_full <= 1'b1;
            end else if (w_wrap && r_pend_full) begin
                r_div       <= r_pend;
                r_pend_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: start/stop, clamping, reload
// handshake and mid-run reset, checked on the falling edge.
module tb_clk_div_gen;
    logic clk;
    logic rst;
    logic en;
    logic o;
    logic tick;
    logic busy;
    int   checks;
    int   errors;

    clk_div_gen_if #(.WIDTH(8)) dif ();

    clk_div_gen #(
        .WIDTH(8),
        .RESET_DIV(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .s_div(dif),
        .o    (o),
        .tick (tick),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_idle(input logic [7:0] v);
        dif.div_in    = v;
        dif.div_valid = 1'b1;
        @(negedge clk);
        dif.div_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b0;
        dif.div_valid = 1'b0;
        dif.div_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({o, tick, busy, dif.div_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset o/tick/busy/rdy got %b want 0001",
                     {o, tick, busy, dif.div_ready});
        end
    endtask

    task automatic test_n2;
        bit ok;
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if ({o, tick, busy} !== {i[0], i[0], 1'b1}) begin
                errors++;
                $display("FAIL n2 cyc %0d o/tick/busy got %b want %b",
                         i, {o, tick, busy}, {i[0], i[0], 1'b1});
            end
        end
        drain(ok);
        checks++;
        if (!ok || o !== 1'b0) begin
            errors++;
            $display("FAIL n2 idle ok=%0d o=%b want 1 0", ok, o);
        end
    endtask

    task automatic test_n5;
        bit ok;
        load_idle(8'd5);
        checks++;
        if (dif.div_ready !== 1'b1) begin
            errors++;
            $display("FAIL n5 rdy got %b want 1", dif.div_ready);
        end
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if ({o, tick} !== {(i % 5) < 2, (i % 5) == 0}) begin
                errors++;
                $display("FAIL n5 cyc %0d o/tick got %b want %b", i,
                         {o, tick}, {(i % 5) < 2, (i % 5) == 0});
            end
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL n5 drain got busy %b want 0", busy);
        end
    endtask

    task automatic test_clamp;
        bit ok;
        logic [7:0] v;
        for (int k = 0; k < 2; k++) begin
            v = 8'(k);
            load_idle(v);
            en = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                checks++;
                if ({o, tick} !== {~i[0], ~i[0]}) begin
                    errors++;
                    $display("FAIL clamp%0d cyc %0d o/tick got %b want %b",
                             k, i, {o, tick}, {~i[0], ~i[0]});
                end
            end
            drain(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL clamp%0d drain busy %b want 0", k, busy);
            end
        end
    endtask

    task automatic test_reload;
        bit ok;
        logic [0:18] eo;
        logic [0:18] et;
        logic [0:18] er;
        eo = 19'b1100111000101011001;
        et = 19'b1000100000101010001;
        er = 19'b1100100000110011111;
        load_idle(8'd4);
        en = 1'b1;
        for (int j = 0; j < 19; j++) begin
            @(negedge clk);
            checks++;
            if ({o, tick, dif.div_ready} !== {eo[j], et[j], er[j]}) begin
                errors++;
                $display("FAIL reload cyc %0d o/tick/rdy got %b want %b", j,
                         {o, tick, dif.div_ready}, {eo[j], et[j], er[j]});
            end
            case (j)
                1:  begin dif.div_in = 8'd6; dif.div_valid = 1'b1; end
                2:  begin dif.div_in = 8'd3; dif.div_valid = 1'b1; end
                4:  begin dif.div_in = 8'd2; dif.div_valid = 1'b1; end
                11: begin dif.div_in = 8'd4; dif.div_valid = 1'b1; end
                default: dif.div_valid = 1'b0;
            endcase
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reload drain busy %b want 0", busy);
        end
    endtask

    task automatic test_stop;
        load_idle(8'd8);
        en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if ({o, tick, busy} !== {j < 4, j == 0, j < 8}) begin
                errors++;
                $display("FAIL stop cyc %0d o/tick/busy got %b want %b", j,
                         {o, tick, busy}, {j < 4, j == 0, j < 8});
            end
            if (j == 1) en = 1'b0;
        end
    endtask

    task automatic test_stop_resume;
        bit ok;
        en = 1'b1;
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            checks++;
            if ({o, tick, busy} !== {(j % 8) < 4, (j % 8) == 0, 1'b1}) begin
                errors++;
                $display("FAIL resume cyc %0d o/tick/busy got %b want %b", j,
                         {o, tick, busy}, {(j % 8) < 4, (j % 8) == 0, 1'b1});
            end
            if (j == 1) en = 1'b0;
            if (j == 5) en = 1'b1;
        end
        drain(ok);
        checks++;
        if (!ok || o !== 1'b0) begin
            errors++;
            $display("FAIL resume idle ok=%0d o=%b want 1 0", ok, o);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        load_idle(8'd6);
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) begin
                dif.div_in = 8'd3;
                dif.div_valid = 1'b1;
            end else begin
                dif.div_valid = 1'b0;
            end
            if (j == 2) begin
                checks++;
                if (dif.div_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid pend rdy got %b want 0",
                             dif.div_ready);
                end
                rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({o, tick, busy, dif.div_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid o/tick/busy/rdy got %b want 0001",
                     {o, tick, busy, dif.div_ready});
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({o, tick} !== {~i[0], ~i[0]}) begin
                errors++;
                $display("FAIL rstmid n2 cyc %0d o/tick got %b want %b",
                         i, {o, tick}, {~i[0], ~i[0]});
            end
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid drain busy %b want 0", busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en = 1'b0;
        dif.div_in = '0;
        dif.div_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_n2();
        test_n5();
        test_clamp();
        test_reload();
        test_stop();
        test_stop_resume();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
